fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the decoder.
- Owns the program counter and issues word reads to instruction memory over a valid/ready request channel with a separate response channel.
- Presents one instruction at a time, with its PC, on instruction_data/instruction_data_valid, held stable until downstream accepts it.
- Accepts redirects (taken branch, jump, trap) from the execute stage and squashes wrong-path fetches.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- INSTRUCTION_WIDTH, 32, fetched word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  read request present.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  ADDR_WIDTH  word address of the request (bits[1:0] always 0).
- imem_resp_valid  input  1  read data returned; never earlier than the cycle after acceptance.
- imem_resp_data  input  INSTRUCTION_WIDTH  returned word.
- imem_resp_error  input  1  access fault; qualified by imem_resp_valid.
- redirect_valid  input  1  replace PC this cycle.
- redirect_pc  input  ADDR_WIDTH  new fetch target.
- instruction_data  output  INSTRUCTION_WIDTH  fetched instruction to the decoder.
- instruction_data_valid  output  1  instruction_data is meaningful.
- instruction_pc  output  ADDR_WIDTH  address of instruction_data.
- instruction_ready  input  1  downstream consumes the instruction this cycle.
- fetch_fault  output  1  sticky fault indication.
- fault_pc  output  ADDR_WIDTH  address that caused the fault.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; state = IDLE.
  - imem_req_valid = 0, instruction_data_valid = 0, fetch_fault = 0, fault_pc = 0.
  - instruction_data = 0, instruction_pc = 0, discard = 0.
- Reset mid-operation: any in-flight response arriving after release is ignored because discard resets to 0 and state is IDLE. The memory must be reset by the same rst.
- States:
  - IDLE: go to REQ on the first cycle out of reset.
  - REQ: imem_req_valid = 1, imem_req_addr = pc. Stay until imem_req_ready, then go to WAIT.
  - WAIT: request outstanding; wait for imem_resp_valid.
  - HALT: fetch_fault = 1; no requests issued.
- Request issue:
  - REQ is entered only when the output register is empty, or is being consumed that cycle (instruction_data_valid && instruction_ready).
  - Otherwise stay in a non-requesting hold until that condition holds.
  - Address and valid stay stable while waiting for ready, except on redirect.
- Response handling in WAIT with discard = 0, on imem_resp_valid:
  - No error: register instruction_data = imem_resp_data, instruction_pc = pc, instruction_data_valid = 1, pc = pc + 4 (modulo 2^ADDR_WIDTH; wrap is legal). Next state REQ if the issue condition holds, else hold.
  - Error: fetch_fault = 1, fault_pc = pc, instruction_data_valid stays 0, go to HALT.
- Latency and throughput:
  - Request accepted in cycle n with response in n+1 gives instruction_data_valid = 1 in n+2.
  - The next request issues no earlier than n+2.
  - Peak throughput is 1 instruction per 2 cycles with single-cycle memory.
- Output handshake: instruction_data_valid falls the cycle after instruction_ready unless a new word is registered in that same edge.
- Redirect (highest priority, any state):
  - Next cycle: pc = redirect_pc, instruction_data_valid = 0.
  - From REQ, not yet accepted: stay in REQ; imem_req_addr retargets to redirect_pc next cycle.
  - Redirect in WAIT, or in the same cycle as acceptance: set discard = 1. The next response is dropped and clears discard, then go to REQ at the redirected pc.
  - Redirect in the same cycle as imem_resp_valid: that response is dropped.
  - Redirect with redirect_pc[1:0] != 0: fetch_fault = 1, fault_pc = redirect_pc, go to HALT (still draining an outstanding response via discard).
  - An aligned redirect in HALT clears fetch_fault and resumes at REQ.
- Simultaneous redirect and instruction_ready: redirect wins; the held instruction is dropped.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTRUCTION_WIDTH and ADDR_WIDTH constants.
  - The fetch_state_t enum (IDLE, REQ, WAIT, HALT).
  - The 4-byte instruction alignment constant.
- Shared by the decoder and later stages.
- Optional sub-module fetch_output_reg: a single-entry valid/ready holding register for data+pc. Everything else lives in fetch_unit.

Test Plan:
- Reset release, memory ready always, 1-cycle response, instruction_ready=1 -> requests to 0x0, 0x4, 0x8 in cycles 1, 3, 5; instruction_data_valid in cycles 3, 5, 7 with matching instruction_pc.
- instruction_ready held 0 for 5 cycles after the first word -> instruction_data/instruction_pc stable, no second request until the ready cycle.
- Redirect to 0x100 while a request to 0x8 is outstanding -> response for 0x8 never appears on the output; next request addr 0x100; instruction_pc 0x100.
- Redirect coincident with imem_resp_valid -> that word dropped; next output carries the redirected pc.
- imem_resp_error on fetch of 0xC -> fetch_fault=1, fault_pc=0xC, no further requests; aligned redirect to 0x200 clears fault and fetches 0x200.
- Redirect to 0x102 -> fetch_fault=1, fault_pc=0x102; rst asserted mid-WAIT -> all outputs zero immediately, first request to RESET_PC after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch FSM states and instruction alignment for the CPU pipeline
package cpu_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int INSTR_ALIGN = 4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_output_reg.sv
// fetch_output_reg: single-entry valid/ready holding register for an instruction and its pc
// ports: i_flush drops the entry, i_load writes i_data/i_pc, i_ready consumes, o_* present the entry
module fetch_output_reg #(
  parameter int DW = cpu_pkg::INSTRUCTION_WIDTH,
  parameter int AW = cpu_pkg::ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic [AW-1:0] i_pc,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [AW-1:0] o_pc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_pc <= '0;
    end else begin
      o_valid <= !i_flush && (i_load || (o_valid && !i_ready));
      if (i_load) begin
        o_data <= i_data;
        o_pc <= i_pc;
      end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the pc, fetches words over a valid/ready imem channel, presents them to the decoder
// ports: imem_req_*/imem_resp_* memory side, redirect_* from execute, instruction_* to decoder, fetch_fault/fault_pc sticky fault
module fetch_unit #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int INSTRUCTION_WIDTH = cpu_pkg::INSTRUCTION_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [ADDR_WIDTH-1:0]        imem_req_addr,
  input  logic                         imem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
  input  logic                         imem_resp_error,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_data,
  output logic                         instruction_data_valid,
  output logic [ADDR_WIDTH-1:0]        instruction_pc,
  input  logic                         instruction_ready,
  output logic                         fetch_fault,
  output logic [ADDR_WIDTH-1:0]        fault_pc
);
  import cpu_pkg::*;
  fetch_state_t r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_next, r_fault_pc, w_fault_pc_next;
  logic r_discard, w_discard_next, r_fault, w_fault_next;
  logic w_issue, w_accept, w_in_flight, w_misaligned, w_load;
  // REQ doubles as the non-requesting hold: the request is only raised once the
  // output slot is free or draining, and it then stays up until accepted
  assign w_issue = !instruction_data_valid || instruction_ready;
  assign imem_req_valid = (r_state == REQ) && w_issue;
  assign imem_req_addr = r_pc;
  assign w_accept = imem_req_valid && imem_req_ready;
  // a response is still owed to us after this edge
  assign w_in_flight = w_accept || ((r_state == WAIT || r_discard) && !imem_resp_valid);
  assign w_misaligned = (redirect_pc & ADDR_WIDTH'(INSTR_ALIGN - 1)) != '0;
  assign w_load = !redirect_valid && r_state == WAIT && imem_resp_valid && !r_discard && !imem_resp_error;
  assign fetch_fault = r_fault;
  assign fault_pc = r_fault_pc;
  always_comb begin
    w_state_next = r_state;
    w_pc_next = r_pc;
    w_discard_next = r_discard;
    w_fault_next = r_fault;
    w_fault_pc_next = r_fault_pc;
    if (redirect_valid) begin
      w_pc_next = redirect_pc;
      w_discard_next = w_in_flight;
      w_state_next = w_misaligned ? HALT : (w_in_flight ? WAIT : REQ);
      w_fault_next = w_misaligned;
      w_fault_pc_next = w_misaligned ? redirect_pc : r_fault_pc;
    end else
      case (r_state)
        IDLE: w_state_next = REQ;
        REQ: w_state_next = w_accept ? WAIT : REQ;
        WAIT:
          if (imem_resp_valid) begin
            w_discard_next = 1'b0;
            w_state_next = (!r_discard && imem_resp_error) ? HALT : REQ;
            w_fault_next = r_fault || (!r_discard && imem_resp_error);
            w_fault_pc_next = (!r_discard && imem_resp_error) ? r_pc : r_fault_pc;
            w_pc_next = w_load ? r_pc + ADDR_WIDTH'(INSTR_ALIGN) : r_pc;
          end
        HALT: w_discard_next = r_discard && !imem_resp_valid;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_discard <= 1'b0;
      r_fault <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc <= w_pc_next;
      r_discard <= w_discard_next;
      r_fault <= w_fault_next;
      r_fault_pc <= w_fault_pc_next;
    end
  fetch_output_reg #(.DW(INSTRUCTION_WIDTH), .AW(ADDR_WIDTH)) u_out (
    .clk(clk),
    .rst(rst),
    .i_flush(redirect_valid),
    .i_load(w_load),
    .i_data(imem_resp_data),
    .i_pc(r_pc),
    .i_ready(instruction_ready),
    .o_valid(instruction_data_valid),
    .o_data(instruction_data),
    .o_pc(instruction_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized stream check of fetch_unit against a memory and stream model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic imem_resp_valid, imem_resp_error;
  logic [31:0] imem_resp_data;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction_data, instruction_pc, fault_pc;
  logic instruction_data_valid, instruction_ready, fetch_fault;
  int checks = 0;
  int failures = 0;
  bit mem_busy;
  logic [31:0] mem_addr;
  int mem_cnt;
  int lat_lo = 1;
  int lat_hi = 1;
  int rdy_pct = 100;
  bit err_en;
  logic [31:0] err_addr;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_error(imem_resp_error),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction_data(instruction_data), .instruction_data_valid(instruction_data_valid),
    .instruction_pc(instruction_pc), .instruction_ready(instruction_ready),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction
  task automatic settle();
    imem_resp_valid = mem_busy && mem_cnt == 0;
    imem_resp_data = imem_resp_valid ? word(mem_addr) : 32'h0;
    imem_resp_error = imem_resp_valid && err_en && mem_addr == err_addr;
    #1;
  endtask
  task automatic advance();
    bit acc;
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      checks++;
      if (mem_busy) begin
        failures++;
        $display("FAIL overlap: request 0x%08h issued while 0x%08h outstanding", imem_req_addr, mem_addr);
      end
    end
    if (imem_resp_valid) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (acc) begin
      mem_busy = 1;
      mem_addr = imem_req_addr;
      mem_cnt = $urandom_range(lat_hi, lat_lo) - 1;
    end
    @(posedge clk);
    @(negedge clk);
    imem_req_ready = $urandom_range(99, 0) < rdy_pct;
  endtask
  task automatic do_reset();
    rst = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    instruction_ready = 1;
    imem_resp_valid = 0;
    imem_resp_data = 0;
    imem_resp_error = 0;
    mem_busy = 0;
    err_en = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    imem_req_ready = $urandom_range(99, 0) < rdy_pct;
  endtask
  task automatic test_reset();
    rst = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    instruction_ready = 1;
    imem_req_ready = 1;
    imem_resp_valid = 0;
    imem_resp_data = 0;
    imem_resp_error = 0;
    @(negedge clk);
    checks += 6;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    if (instruction_data_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", instruction_data_valid); end
    if (instruction_data !== 32'h0) begin failures++; $display("FAIL reset_data got=0x%08h exp=0", instruction_data); end
    if (instruction_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=0x%08h exp=0", instruction_pc); end
    if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
    if (fault_pc !== 32'h0) begin failures++; $display("FAIL reset_fault_pc got=0x%08h exp=0", fault_pc); end
  endtask
  task automatic test_stream();
    bit e_req, e_out;
    lat_lo = 1; lat_hi = 1; rdy_pct = 100;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      settle();
      e_req = (c % 2) == 1;
      e_out = c >= 3 && (c % 2) == 1;
      checks += 2;
      if (imem_req_valid !== e_req) begin failures++; $display("FAIL stream_req_valid c=%0d got=%b exp=%b", c, imem_req_valid, e_req); end
      if (instruction_data_valid !== e_out) begin failures++; $display("FAIL stream_out_valid c=%0d got=%b exp=%b", c, instruction_data_valid, e_out); end
      if (e_req) begin
        checks++;
        if (imem_req_addr !== 32'((c - 1) * 2)) begin failures++; $display("FAIL stream_req_addr c=%0d got=0x%08h exp=0x%08h", c, imem_req_addr, 32'((c - 1) * 2)); end
      end
      if (e_out) begin
        checks += 2;
        if (instruction_pc !== 32'((c - 3) * 2)) begin failures++; $display("FAIL stream_pc c=%0d got=0x%08h exp=0x%08h", c, instruction_pc, 32'((c - 3) * 2)); end
        if (instruction_data !== word(32'((c - 3) * 2))) begin failures++; $display("FAIL stream_data c=%0d got=0x%08h exp=0x%08h", c, instruction_data, word(32'((c - 3) * 2))); end
      end
      advance();
    end
  endtask
  task automatic test_stall();
    lat_lo = 1; lat_hi = 1; rdy_pct = 100;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      instruction_ready = !(c >= 3 && c <= 7);
      settle();
      if (c >= 3 && c <= 8) begin
        checks += 4;
        if (instruction_data_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c=%0d got=%b exp=1", c, instruction_data_valid); end
        if (instruction_pc !== 32'h0) begin failures++; $display("FAIL stall_pc c=%0d got=0x%08h exp=0", c, instruction_pc); end
        if (instruction_data !== word(32'h0)) begin failures++; $display("FAIL stall_data c=%0d got=0x%08h exp=0x%08h", c, instruction_data, word(32'h0)); end
        if (imem_req_valid !== (c == 8)) begin failures++; $display("FAIL stall_req_valid c=%0d got=%b exp=%b", c, imem_req_valid, c == 8); end
      end
      if (c == 8) begin
        checks++;
        if (imem_req_addr !== 32'h4) begin failures++; $display("FAIL stall_req_addr got=0x%08h exp=0x4", imem_req_addr); end
      end
      if (c == 9) begin
        checks++;
        if (instruction_data_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", instruction_data_valid); end
      end
      advance();
    end
  endtask
  task automatic check_after_redirect(input string tag, input logic [31:0] tgt, input logic [31:0] bad_pc);
    bit seen_out, seen_req, saw_bad;
    seen_out = 0; seen_req = 0; saw_bad = 0;
    for (int i = 0; i < 30; i++) begin
      settle();
      if (instruction_data_valid && instruction_pc == bad_pc) saw_bad = 1;
      if (!seen_req && imem_req_valid && imem_req_ready) begin
        seen_req = 1;
        checks++;
        if (imem_req_addr !== tgt) begin failures++; $display("FAIL %s_req_addr got=0x%08h exp=0x%08h", tag, imem_req_addr, tgt); end
      end
      if (!seen_out && instruction_data_valid) begin
        seen_out = 1;
        checks += 2;
        if (instruction_pc !== tgt) begin failures++; $display("FAIL %s_pc got=0x%08h exp=0x%08h", tag, instruction_pc, tgt); end
        if (instruction_data !== word(tgt)) begin failures++; $display("FAIL %s_data got=0x%08h exp=0x%08h", tag, instruction_data, word(tgt)); end
      end
      advance();
    end
    checks++;
    if (saw_bad || !seen_out) begin failures++; $display("FAIL %s_stream dropped_word_seen=%b target_seen=%b exp=0/1", tag, saw_bad, seen_out); end
  endtask
  task automatic test_redirect_wait();
    bit found;
    lat_lo = 3; lat_hi = 3; rdy_pct = 100;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      settle();
      found = imem_req_valid && imem_req_ready && imem_req_addr == 32'h8;
      advance();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rw_accept8 got=timeout exp=request 0x8"); end
    redirect_valid = 1; redirect_pc = 32'h100;
    settle();
    advance();
    redirect_valid = 0;
    check_after_redirect("rw", 32'h100, 32'h8);
  endtask
  task automatic test_redirect_resp();
    bit hit;
    lat_lo = 1; lat_hi = 1; rdy_pct = 100;
    do_reset();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (mem_busy && mem_cnt == 0 && mem_addr == 32'h4) begin
        hit = 1; redirect_valid = 1; redirect_pc = 32'h40;
      end
      settle();
      advance();
      redirect_valid = 0;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rr_resp4 got=timeout exp=response for 0x4"); end
    check_after_redirect("rr", 32'h40, 32'h4);
  endtask
  task automatic test_error_fault();
    bit got;
    lat_lo = 1; lat_hi = 1; rdy_pct = 100;
    do_reset();
    err_en = 1; err_addr = 32'hC;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      settle();
      got = fetch_fault;
      if (!got) advance();
    end
    checks += 3;
    if (!got) begin failures++; $display("FAIL err_fault got=timeout exp=fetch_fault"); end
    if (fault_pc !== 32'hC) begin failures++; $display("FAIL err_fault_pc got=0x%08h exp=0xc", fault_pc); end
    if (instruction_data_valid !== 1'b0) begin failures++; $display("FAIL err_out_valid got=%b exp=0", instruction_data_valid); end
    for (int i = 0; i < 5; i++) begin
      advance();
      settle();
      checks += 2;
      if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL halt_req_valid got=%b exp=0", imem_req_valid); end
      if (fetch_fault !== 1'b1) begin failures++; $display("FAIL halt_fault got=%b exp=1", fetch_fault); end
    end
    err_en = 0;
    redirect_valid = 1; redirect_pc = 32'h200;
    advance();
    redirect_valid = 0;
    settle();
    checks++;
    if (fetch_fault !== 1'b0) begin failures++; $display("FAIL halt_clear got=%b exp=0", fetch_fault); end
    check_after_redirect("hr", 32'h200, 32'hC);
  endtask
  task automatic test_misaligned_reset();
    bit got;
    lat_lo = 1; lat_hi = 1; rdy_pct = 100;
    do_reset();
    for (int i = 0; i < 4; i++) begin settle(); advance(); end
    redirect_valid = 1; redirect_pc = 32'h102;
    settle();
    advance();
    redirect_valid = 0;
    settle();
    checks += 3;
    if (fetch_fault !== 1'b1) begin failures++; $display("FAIL mis_fault got=%b exp=1", fetch_fault); end
    if (fault_pc !== 32'h102) begin failures++; $display("FAIL mis_fault_pc got=0x%08h exp=0x102", fault_pc); end
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_req_valid got=%b exp=0", imem_req_valid); end
    redirect_valid = 1; redirect_pc = 32'h300;
    advance();
    redirect_valid = 0;
    lat_lo = 3; lat_hi = 3;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      settle();
      got = imem_req_valid && imem_req_ready && imem_req_addr == 32'h304;
      advance();
    end
    checks++;
    if (!got) begin failures++; $display("FAIL mis_resume got=timeout exp=request 0x304"); end
    settle();
    #2 rst = 1;
    #1;
    checks += 6;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL arst_req_valid got=%b exp=0", imem_req_valid); end
    if (instruction_data_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", instruction_data_valid); end
    if (instruction_data !== 32'h0) begin failures++; $display("FAIL arst_data got=0x%08h exp=0", instruction_data); end
    if (instruction_pc !== 32'h0) begin failures++; $display("FAIL arst_pc got=0x%08h exp=0", instruction_pc); end
    if (fetch_fault !== 1'b0) begin failures++; $display("FAIL arst_fault got=%b exp=0", fetch_fault); end
    if (fault_pc !== 32'h0) begin failures++; $display("FAIL arst_fault_pc got=0x%08h exp=0", fault_pc); end
    mem_busy = 0;
    imem_resp_valid = 0;
    @(negedge clk);
    rst = 0;
    lat_lo = 1; lat_hi = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (c < 2) begin
        checks++;
        if (imem_req_valid !== (c == 1)) begin failures++; $display("FAIL arst_first_req c=%0d got=%b exp=%b", c, imem_req_valid, c == 1); end
      end
      if (c == 1) begin
        checks++;
        if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL arst_first_addr got=0x%08h exp=0", imem_req_addr); end
      end
      if (c == 3) begin
        checks += 2;
        if (instruction_data_valid !== 1'b1) begin failures++; $display("FAIL arst_first_out got=%b exp=1", instruction_data_valid); end
        if (instruction_pc !== 32'h0) begin failures++; $display("FAIL arst_first_pc got=0x%08h exp=0", instruction_pc); end
      end
      advance();
    end
  endtask
  task automatic test_random();
    logic [31:0] exp_pc, prev_pc, prev_data, prev_addr;
    bit prev_hold, prev_req;
    int consumed;
    lat_lo = 1; lat_hi = 3; rdy_pct = 70;
    do_reset();
    exp_pc = 32'h0;
    prev_hold = 0; prev_req = 0; consumed = 0;
    prev_pc = 0; prev_data = 0; prev_addr = 0;
    for (int i = 0; i < 3000; i++) begin
      instruction_ready = $urandom_range(99, 0) < 70;
      redirect_valid = $urandom_range(99, 0) < 3;
      redirect_pc = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(1023, 0)) << 2);
      settle();
      if (prev_hold) begin
        checks++;
        if (!(instruction_data_valid === 1'b1 && instruction_pc === prev_pc && instruction_data === prev_data)) begin
          failures++; $display("FAIL rnd_hold i=%0d got=%b/0x%08h exp=1/0x%08h", i, instruction_data_valid, instruction_pc, prev_pc);
        end
      end
      if (prev_req) begin
        checks++;
        if (!(imem_req_valid === 1'b1 && imem_req_addr === prev_addr)) begin
          failures++; $display("FAIL rnd_req_stable i=%0d got=%b/0x%08h exp=1/0x%08h", i, imem_req_valid, imem_req_addr, prev_addr);
        end
      end
      if (instruction_data_valid) begin
        checks++;
        if (instruction_pc !== exp_pc || instruction_data !== word(exp_pc)) begin
          failures++; $display("FAIL rnd_word i=%0d got=0x%08h/0x%08h exp=0x%08h/0x%08h", i, instruction_pc, instruction_data, exp_pc, word(exp_pc));
        end
      end
      if (redirect_valid) exp_pc = redirect_pc;
      else if (instruction_data_valid && instruction_ready) begin
        exp_pc += 32'h4;
        consumed++;
      end
      prev_hold = instruction_data_valid && !instruction_ready && !redirect_valid;
      prev_req = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_pc = instruction_pc; prev_data = instruction_data; prev_addr = imem_req_addr;
      advance();
    end
    redirect_valid = 0;
    checks++;
    if (consumed < 200) begin failures++; $display("FAIL rnd_progress got=%0d exp>=200", consumed); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_error_fault();
    test_misaligned_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
